// File: rtl/dpram_stream_reader_pkg.sv
// Shared NoU definitions for the RAM-backed stream reader: output buffer
// depth, buffer operation encoding and the circular pointer difference.
package dpram_stream_reader_pkg;

  // Output buffer entries; the credit arithmetic assumes exactly two.
  localparam int unsigned OBUF_DEPTH = 2;

  // Widest pointer the difference helper handles; callers truncate the
  // result to their own pointer width, which yields the modulo result.
  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Output buffer operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  // Circular occupancy between a write and a read pointer.
  function automatic ptr_max_t ptr_occ(input ptr_max_t wr, input ptr_max_t rd);
    return wr - rd;
  endfunction

endpackage

// File: rtl/dpram_out_buf.sv
// Two-entry valid/ready output FIFO. The head word is held in its own
// register so the stream output never comes straight from the RAM.
module dpram_out_buf
  import dpram_stream_reader_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] head_data,
  output logic                 head_valid,
  output logic [1:0]           count
);

  logic [DATAWIDTH-1:0] head_q, head_d;
  logic [DATAWIDTH-1:0] tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  buf_op_e              op_s;

  // Next-state for head, tail and count; flush empties the buffer.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    op_s   = buf_op_e'({push, pop});
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (op_s)
        BUF_PUSH: begin
          if (cnt_q == 2'd0) begin
            head_d = push_data;
            cnt_d  = 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_d = push_data;
            cnt_d  = 2'd2;
          end else begin
            cnt_d = cnt_q;  // full: upstream credits never allow this
          end
        end
        BUF_POP: begin
          head_d = tail_q;
          cnt_d  = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
        end
        BUF_BOTH: begin
          // Head advances and the tail is written on the same edge.
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_data;
          end else begin
            head_d = push_data;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= {DATAWIDTH{1'b0}};
      tail_q <= {DATAWIDTH{1'b0}};
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Head register and count straight to the outputs.
  always_comb begin
    head_data  = head_q;
    head_valid = (cnt_q != 2'd0);
    count      = cnt_q;
  end

endmodule

// File: rtl/dpram_stream_reader_chk.sv
// Protocol checker for the stream reader: the producer must never run more
// than one full RAM ahead of the reader.
module dpram_stream_reader_chk
  import dpram_stream_reader_pkg::*;
#(
  parameter int MEMDEPTH = 32,
  parameter int PTRWIDTH = $clog2(MEMDEPTH) + 1
) (
  input logic                clk,
  input logic                rst_n,
  input logic [PTRWIDTH-1:0] wr_ptr,
  input logic [PTRWIDTH-1:0] rd_ptr
);

  logic [PTRWIDTH-1:0] occ_s;

  // Occupancy as seen by the checker.
  always_comb begin
    occ_s = PTRWIDTH'(ptr_occ(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr)));
  end

  occ_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    occ_s <= PTRWIDTH'(MEMDEPTH))
    else $error("producer overran reader: occupancy %0d", occ_s);

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side controller of a RAM-backed circular buffer: issues RAM reads
// against a credit budget, absorbs the one-cycle read latency in a two-entry
// output buffer and returns its read pointer to the producer.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int MEMDEPTH  = 32,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = $clog2(MEMDEPTH),
  parameter int PTRWIDTH  = ADDRWIDTH + 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [PTRWIDTH-1:0]  WrPtr,
  input  logic                 Flush,
  output logic [ADDRWIDTH-1:0] RamReadAddr,
  output logic                 RamReadEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut,
  output logic [PTRWIDTH-1:0]  RdPtr,
  output logic [DATAWIDTH-1:0] Dout,
  output logic                 DoutValid,
  input  logic                 DoutReady,
  output logic                 Empty,
  output logic [PTRWIDTH-1:0]  Level
);

  logic [PTRWIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                 inflight_q, inflight_d;
  logic [PTRWIDTH-1:0]  occ_s;
  logic                 pop_s;
  logic                 issue_s;
  logic                 push_s;
  logic [2:0]           credit_s;
  logic [1:0]           buf_cnt_s;
  logic                 buf_valid_s;
  logic [DATAWIDTH-1:0] buf_head_s;

  // Read issue decision and next pointer / in-flight state. Flush wins over
  // both issue and capture; a popped slot is usable on the same cycle.
  always_comb begin
    occ_s    = PTRWIDTH'(ptr_occ(PTR_MAX_W'(WrPtr), PTR_MAX_W'(rd_ptr_q)));
    pop_s    = buf_valid_s & DoutReady;
    credit_s = 3'(OBUF_DEPTH) + {2'b00, pop_s} - {1'b0, buf_cnt_s} - {2'b00, inflight_q};
    issue_s  = (occ_s != {PTRWIDTH{1'b0}}) & (credit_s != 3'd0) & ~Flush;
    push_s   = inflight_q & ~Flush;
    if (Flush) begin
      rd_ptr_d = WrPtr;
    end else if (issue_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTRWIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    inflight_d = issue_s;
  end

  // Read pointer and in-flight flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr_q   <= {PTRWIDTH{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  dpram_out_buf #(
    .DATAWIDTH (DATAWIDTH)
  ) u_out_buf (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .flush      (Flush),
    .push       (push_s),
    .push_data  (RamDataOut),
    .pop        (pop_s),
    .head_data  (buf_head_s),
    .head_valid (buf_valid_s),
    .count      (buf_cnt_s)
  );

  // Port drive: RAM read port, returned pointer, stream and status.
  always_comb begin
    RamReadAddr   = rd_ptr_q[ADDRWIDTH-1:0];
    RamReadEnable = issue_s;
    RdPtr         = rd_ptr_q;
    Dout          = buf_head_s;
    DoutValid     = buf_valid_s;
    Empty         = (occ_s == {PTRWIDTH{1'b0}}) & ~inflight_q & (buf_cnt_s == 2'd0);
    Level         = occ_s + {{(PTRWIDTH-1){1'b0}}, inflight_q}
                          + {{(PTRWIDTH-2){1'b0}}, buf_cnt_s};
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: a RAM model with one-cycle read latency, a
// producer writing words and bumping WrPtr, and a queue of words written but
// not yet consumed as the reference for data order, Level and Empty.
module tb_dpram_stream_reader;

  localparam int MD = 32;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 6;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b1;
  logic [PW-1:0] WrPtr = '0;
  logic          Flush = 1'b0;
  logic          DoutReady = 1'b0;
  logic [AW-1:0] RamReadAddr;
  logic          RamReadEnable;
  logic [DW-1:0] RamDataOut;
  logic [PW-1:0] RdPtr;
  logic [DW-1:0] Dout;
  logic          DoutValid;
  logic          Empty;
  logic [PW-1:0] Level;

  logic [DW-1:0] mem [MD];
  logic [DW-1:0] exp_q [$];
  int            addr_log [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_reads = 0;
  bit            mon_en = 1'b0;
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_flush = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  always #5 Clk = ~Clk;

  dpram_stream_reader #(.MEMDEPTH(MD), .DATAWIDTH(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WrPtr(WrPtr), .Flush(Flush),
    .RamReadAddr(RamReadAddr), .RamReadEnable(RamReadEnable),
    .RamDataOut(RamDataOut), .RdPtr(RdPtr), .Dout(Dout),
    .DoutValid(DoutValid), .DoutReady(DoutReady), .Empty(Empty), .Level(Level)
  );

  dpram_stream_reader_chk #(.MEMDEPTH(MD), .PTRWIDTH(PW)) u_chk (
    .clk(Clk), .rst_n(Rst_n), .wr_ptr(WrPtr), .rd_ptr(RdPtr)
  );

  // RAM read port with one cycle of latency; also logs issued reads.
  always @(posedge Clk) begin
    if (RamReadEnable) begin
      RamDataOut <= mem[RamReadAddr];
      n_reads++;
      addr_log.push_back(int'(RamReadAddr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: occupancy, emptiness, in-order data and AXI-style hold.
  always @(negedge Clk) begin
    if (mon_en) begin
      chk("level", 64'(Level), 64'(exp_q.size()));
      chk("empty", 64'(Empty), 64'(exp_q.size() == 0));
      if (prev_valid && !prev_ready && !prev_flush) begin
        chk("hold_valid", 64'(DoutValid), 64'd1);
        chk("hold_data", 64'(Dout), 64'(prev_dout));
      end
      if (DoutValid && DoutReady) begin
        if (exp_q.size() > 0) chk("stream_data", 64'(Dout), 64'(exp_q.pop_front()));
        else chk("spurious_word", 64'(DoutValid), 64'd0);
      end
    end
    prev_valid = DoutValid;
    prev_ready = DoutReady;
    prev_flush = Flush;
    prev_dout  = Dout;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[WrPtr[AW-1:0]] = d;
    WrPtr = WrPtr + 6'd1;
    exp_q.push_back(d);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!DoutValid && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(DoutValid), 64'd1);
  endtask

  initial begin
    // Reset state
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_rdptr", 64'(RdPtr), 64'd0);
    chk("rst_valid", 64'(DoutValid), 64'd0);
    chk("rst_ren", 64'(RamReadEnable), 64'd0);
    chk("rst_dout", 64'(Dout), 64'd0);
    chk("rst_empty", 64'(Empty), 64'd1);
    chk("rst_level", 64'(Level), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single word: issue in cycle 0, valid in cycle 2, empty in cycle 3
    DoutReady = 1'b1;
    push_word(32'hA5A5_0001);
    #1;
    chk("single_ren", 64'(RamReadEnable), 64'd1);
    chk("single_addr", 64'(RamReadAddr), 64'd0);
    tick();
    chk("single_c1_valid", 64'(DoutValid), 64'd0);
    chk("single_rdptr", 64'(RdPtr), 64'd1);
    tick();
    chk("single_c2_valid", 64'(DoutValid), 64'd1);
    chk("single_c2_dout", 64'(Dout), 64'hA5A5_0001);
    tick();
    chk("single_c3_empty", 64'(Empty), 64'd1);

    // Streaming: eight words back to back with no bubbles
    for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
    wait_valid("stream_start", 10);
    for (int i = 0; i < 8; i++) begin
      chk("stream_nobubble", 64'(DoutValid), 64'd1);
      chk("stream_order", 64'(Dout), 64'(32'h10 + 32'(i)));
      tick();
    end
    chk("stream_done_empty", 64'(Empty), 64'd1);

    // Back-pressure: only two reads fit while the consumer stalls
    DoutReady = 1'b0;
    n_reads = 0;
    for (int i = 0; i < 4; i++) push_word(32'h20 + 32'(i));
    tick(6);
    chk("bp_reads", 64'(n_reads), 64'd2);
    chk("bp_ren_off", 64'(RamReadEnable), 64'd0);
    chk("bp_valid", 64'(DoutValid), 64'd1);
    chk("bp_head", 64'(Dout), 64'h20);
    DoutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_level", 64'(Level), 64'(4 - i));
      tick();
    end

    // Wrap: park both pointers at 30 then read 30,31,0,1
    mon_en = 1'b0;
    DoutReady = 1'b0;
    WrPtr = 6'd30;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    mon_en = 1'b1;
    chk("wrap_start_rdptr", 64'(RdPtr), 64'd30);
    DoutReady = 1'b1;
    addr_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_word(32'h30 + 32'(i));
      tick();
    end
    tick(6);
    chk("wrap_nreads", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("wrap_addr", 64'(addr_log[i]), 64'((30 + i) % MD));
    chk("wrap_rdptr", 64'(RdPtr), 64'd34);

    // Flush with a buffered word and a word in flight
    DoutReady = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h40 + 32'(i));
    tick(2);
    chk("preflush_valid", 64'(DoutValid), 64'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    exp_q.delete();
    chk("flush_valid", 64'(DoutValid), 64'd0);
    chk("flush_rdptr", 64'(RdPtr), 64'(WrPtr));
    chk("flush_rdptr_abs", 64'(RdPtr), 64'd40);
    chk("flush_level", 64'(Level), 64'd0);
    chk("flush_empty", 64'(Empty), 64'd1);
    DoutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_ghost", 64'(DoutValid), 64'd0);
      tick();
    end
    push_word(32'hF1F1_0000);
    wait_valid("post_flush_word", 6);
    tick();

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic [PW-1:0] occ_tb;
      DoutReady = ($urandom_range(0, 3) != 0);
      occ_tb = WrPtr - RdPtr;
      if ($urandom_range(0, 1) == 1 && occ_tb < 6'd32) push_word($urandom());
      tick();
    end
    DoutReady = 1'b1;
    for (int k = 0; k < 100 && !(Empty && exp_q.size() == 0); k++) tick();
    chk("drain_empty", 64'(Empty), 64'd1);
    chk("drain_rdptr", 64'(RdPtr), 64'(WrPtr));
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream: state clears before the next edge
    for (int i = 0; i < 10; i++) push_word(32'h50 + 32'(i));
    tick(3);
    mon_en = 1'b0;
    #3;
    Rst_n = 1'b0;
    WrPtr = 6'd0;
    #1;
    chk("arst_valid", 64'(DoutValid), 64'd0);
    chk("arst_ren", 64'(RamReadEnable), 64'd0);
    chk("arst_rdptr", 64'(RdPtr), 64'd0);
    chk("arst_level", 64'(Level), 64'd0);
    exp_q.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    tick(2);
    chk("arst_empty", 64'(Empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
